// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bus between the two-requester arbiter and the shared memory.
//   mem_req        : access request to the memory (arbiter -> memory)
//   mem_r_w_type   : 0 = read, 1 = write              (arbiter -> memory)
//   mem_addr       : 10-bit byte address              (arbiter -> memory)
//   mem_write_data : 32-bit write data                (arbiter -> memory)
//   mem_read_data  : 32-bit read data, valid with mem_done (memory -> arbiter)
//   mem_done       : access completion                (memory -> arbiter)
// Modports: master = arbiter side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        mem_req;
  logic        mem_r_w_type;
  logic [9:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_done;

  modport master (
    output mem_req,
    output mem_r_w_type,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_r_w_type,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data,
    output mem_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates two requesters onto one shared memory. A three-state FSM
// (IDLE -> BUSY -> RESP) grants one requester, latches its command into the
// mem_* registers, waits for mem_done, then pulses that requester's done.
// Ties are broken round-robin using the last granted requester.
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN : when defined, requester 0 always wins a tie.
//
// Ports:
//   clk                       : rising-edge clock
//   reset                     : synchronous, active-high reset
//   req0 / req1               : requests, held until their done pulse
//   r_w_type0 / r_w_type1     : 0 = read, 1 = write
//   addr0 / addr1             : 10-bit byte address
//   write_data0 / write_data1 : 32-bit write data
//   read_data0 / read_data1   : registered read result per requester
//   done0 / done1             : one-cycle completion pulse per requester
//   busy                      : high while in BUSY or RESP
//   mem_bus                   : memory bus (master side)
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 r_w_type0,
  input  logic                 r_w_type1,
  input  logic [9:0]           addr0,
  input  logic [9:0]           addr1,
  input  logic [31:0]          write_data0,
  input  logic [31:0]          write_data1,
  output logic [31:0]          read_data0,
  output logic [31:0]          read_data1,
  output logic                 done0,
  output logic                 done1,
  output logic                 busy,
  mem_arbiter_if.master        mem_bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_r;
  logic        last_grant_r;
  logic        grant_r;
  logic        mem_req_r;
  logic        mem_r_w_type_r;
  logic [9:0]  mem_addr_r;
  logic [31:0] mem_write_data_r;
  logic [31:0] read_data0_r;
  logic [31:0] read_data1_r;
  logic        done0_r;
  logic        done1_r;
  logic        busy_r;
  logic        req_any_s;
  logic        grant_sel_s;

  // Arbitration: pick the requester to grant if the FSM is in IDLE.
  always_comb begin
    req_any_s   = req0 | req1;
    grant_sel_s = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_sel_s = 1'b0;
`else
      // Grant whoever was not served last; last_grant resets to 1 so
      // requester 0 wins the first tie.
      grant_sel_s = ~last_grant_r;
`endif
    end else if (req1) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
  end

  // FSM, command latches, read-data capture and done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      last_grant_r     <= 1'b1;
      grant_r          <= 1'b0;
      mem_req_r        <= 1'b0;
      mem_r_w_type_r   <= 1'b0;
      mem_addr_r       <= 10'h000;
      mem_write_data_r <= 32'h0000_0000;
      read_data0_r     <= 32'h0000_0000;
      read_data1_r     <= 32'h0000_0000;
      done0_r          <= 1'b0;
      done1_r          <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          if (req_any_s) begin
            // Requester inputs are only looked at here; BUSY works
            // purely from the latched copies.
            grant_r          <= grant_sel_s;
            mem_req_r        <= 1'b1;
            busy_r           <= 1'b1;
            state_r          <= BUSY;
            mem_r_w_type_r   <= grant_sel_s ? r_w_type1   : r_w_type0;
            mem_addr_r       <= grant_sel_s ? addr1       : addr0;
            mem_write_data_r <= grant_sel_s ? write_data1 : write_data0;
          end else begin
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_bus.mem_done) begin
            state_r   <= RESP;
            mem_req_r <= 1'b0;
            if (grant_r) begin
              done1_r <= 1'b1;
            end else begin
              done0_r <= 1'b1;
            end
            // Only reads update the requester's read register.
            if (!mem_r_w_type_r) begin
              if (grant_r) begin
                read_data1_r <= mem_bus.mem_read_data;
              end else begin
                read_data0_r <= mem_bus.mem_read_data;
              end
            end
          end
        end
        RESP: begin
          done0_r      <= 1'b0;
          done1_r      <= 1'b0;
          busy_r       <= 1'b0;
          mem_req_r    <= 1'b0;
          last_grant_r <= grant_r;
          state_r      <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          done0_r   <= 1'b0;
          done1_r   <= 1'b0;
        end
      endcase
    end
  end

  assign read_data0             = read_data0_r;
  assign read_data1             = read_data1_r;
  assign done0                  = done0_r;
  assign done1                  = done1_r;
  assign busy                   = busy_r;
  assign mem_bus.mem_req        = mem_req_r;
  assign mem_bus.mem_r_w_type   = mem_r_w_type_r;
  assign mem_bus.mem_addr       = mem_addr_r;
  assign mem_bus.mem_write_data = mem_write_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed, self-checking bench for mem_arbiter. The bench plays the memory
// by driving mem_done / mem_read_data on the interface. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  logic        clk;
  logic        reset;
  logic        req0;
  logic        req1;
  logic        r_w_type0;
  logic        r_w_type1;
  logic [9:0]  addr0;
  logic [9:0]  addr1;
  logic [31:0] write_data0;
  logic [31:0] write_data1;
  logic [31:0] read_data0;
  logic [31:0] read_data1;
  logic        done0;
  logic        done1;
  logic        busy;

  int checks;
  int errors;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .r_w_type0   (r_w_type0),
    .r_w_type1   (r_w_type1),
    .addr0       (addr0),
    .addr1       (addr1),
    .write_data0 (write_data0),
    .write_data1 (write_data1),
    .read_data0  (read_data0),
    .read_data1  (read_data1),
    .done0       (done0),
    .done1       (done1),
    .busy        (busy),
    .mem_bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({done0, done1} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {done0, done1}); end
    checks++; if (bus.mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
    checks++; if (bus.mem_write_data !== 32'h0 || bus.mem_r_w_type !== 1'b0) begin errors++; $display("FAIL reset_mem_cmd: got %b/%h want 0/00000000", bus.mem_r_w_type, bus.mem_write_data); end
    checks++; if (read_data0 !== 32'h0 || read_data1 !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h/%h want 0/0", read_data0, read_data1); end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; r_w_type0 = 1'b0; addr0 = 10'h014;
    tick();  // first BUSY cycle
    checks++; if (bus.mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL read_busy: mem_req=%b busy=%b want 1/1", bus.mem_req, busy); end
    checks++; if (bus.mem_addr !== 10'h014 || bus.mem_r_w_type !== 1'b0) begin errors++; $display("FAIL read_mem_addr: got %h/%b want 014/0", bus.mem_addr, bus.mem_r_w_type); end
    checks++; if ({done0, done1} !== 2'b00) begin errors++; $display("FAIL read_early_done: got %b want 00", {done0, done1}); end
    bus.mem_done = 1'b1; bus.mem_read_data = 32'hDEADBEEF;
    tick();  // RESP
    bus.mem_done = 1'b0; bus.mem_read_data = 32'h0;
    checks++; if ({done0, done1} !== 2'b10) begin errors++; $display("FAIL read_done: got %b want 10", {done0, done1}); end
    checks++; if (read_data0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data0: got %h want deadbeef", read_data0); end
    checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL read_resp: mem_req=%b busy=%b want 0/1", bus.mem_req, busy); end
    req0 = 1'b0;
    tick();  // IDLE
    checks++; if ({done0, done1} !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL read_idle: done=%b busy=%b want 00/0", {done0, done1}, busy); end
    checks++; if (read_data0 !== 32'hDEADBEEF || read_data1 !== 32'h0) begin errors++; $display("FAIL read_hold: got %h/%h want deadbeef/0", read_data0, read_data1); end
  endtask

  task automatic test_write();
    req1 = 1'b1; r_w_type1 = 1'b1; addr1 = 10'h02C; write_data1 = 32'h0011_4514;
    tick();  // BUSY
    checks++; if (bus.mem_r_w_type !== 1'b1 || bus.mem_write_data !== 32'h0011_4514 || bus.mem_addr !== 10'h02C) begin errors++; $display("FAIL write_cmd: got %b/%h/%h want 1/00114514/02c", bus.mem_r_w_type, bus.mem_write_data, bus.mem_addr); end
    bus.mem_done = 1'b1; bus.mem_read_data = 32'hCAFEF00D;
    tick();  // RESP
    bus.mem_done = 1'b0; bus.mem_read_data = 32'h0;
    checks++; if ({done0, done1} !== 2'b01) begin errors++; $display("FAIL write_done: got %b want 01", {done0, done1}); end
    checks++; if (read_data1 !== 32'h0 || read_data0 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_data: got %h/%h want deadbeef/0", read_data0, read_data1); end
    req1 = 1'b0;
    tick();  // IDLE
    checks++; if ({done0, done1} !== 2'b00) begin errors++; $display("FAIL write_done_pulse: got %b want 00", {done0, done1}); end
  endtask

  task automatic test_tie();
    logic exp_grant [4];
    logic [9:0] exp_addr;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    req0 = 1'b1; r_w_type0 = 1'b0; addr0 = 10'h100;
    req1 = 1'b1; r_w_type1 = 1'b0; addr1 = 10'h200;
    for (int i = 0; i < 4; i++) begin
      tick();  // BUSY
      exp_addr = exp_grant[i] ? 10'h200 : 10'h100;
      checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL tie_grant[%0d]: mem_addr=%h want %h", i, bus.mem_addr, exp_addr); end
      bus.mem_done = 1'b1; bus.mem_read_data = 32'h0000_1000 + i;
      tick();  // RESP
      bus.mem_done = 1'b0;
      checks++; if ({done0, done1} !== (exp_grant[i] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_done[%0d]: got %b want %b", i, {done0, done1}, exp_grant[i] ? 2'b01 : 2'b10); end
      checks++; if ((exp_grant[i] ? read_data1 : read_data0) !== 32'h0000_1000 + i) begin errors++; $display("FAIL tie_read_data[%0d]: got %h/%h", i, read_data0, read_data1); end
      tick();  // IDLE, both requests still high
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL tie_idle: busy=%b mem_req=%b want 0/0", busy, bus.mem_req); end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    req0 = 1'b1; r_w_type0 = 1'b0; addr0 = 10'h3FF;
    tick();  // BUSY cycle 1
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h3FF || busy !== 1'b1 || {done0, done1} !== 2'b00) bad++;
      if (i == 5) begin
        addr0 = 10'h001; r_w_type0 = 1'b1; req1 = 1'b1; addr1 = 10'h055;
      end
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable: %0d bad cycles want 0", bad); end
    checks++; if (bus.mem_addr !== 10'h3FF || bus.mem_r_w_type !== 1'b0) begin errors++; $display("FAIL stall_addr: got %h/%b want 3ff/0", bus.mem_addr, bus.mem_r_w_type); end
    bus.mem_done = 1'b1; bus.mem_read_data = 32'h55AA_55AA;
    tick();  // RESP
    bus.mem_done = 1'b0;
    checks++; if ({done0, done1} !== 2'b10 || read_data0 !== 32'h55AA_55AA) begin errors++; $display("FAIL stall_done: done=%b rd0=%h want 10/55aa55aa", {done0, done1}, read_data0); end
    req0 = 1'b0; req1 = 1'b0; addr0 = 10'h000; r_w_type0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int pulses;
    pulses = 0;
    req1 = 1'b1; r_w_type1 = 1'b0; addr1 = 10'h0AA;
    tick();  // BUSY 1
    tick();  // BUSY 2
    tick();  // BUSY 3
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h0AA) begin errors++; $display("FAIL rst_pre_busy: mem_req=%b addr=%h want 1/0aa", bus.mem_req, bus.mem_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0; req1 = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== 10'h000) begin errors++; $display("FAIL rst_mid_idle: mem_req=%b busy=%b addr=%h want 0/0/000", bus.mem_req, busy, bus.mem_addr); end
    checks++; if (read_data0 !== 32'h0) begin errors++; $display("FAIL rst_mid_read_data: got %h want 0", read_data0); end
    bus.mem_done = 1'b1; bus.mem_read_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      if (done0 === 1'b1 || done1 === 1'b1 || busy !== 1'b0) pulses++;
      tick();
    end
    bus.mem_done = 1'b0;
    checks++; if (pulses !== 0 || read_data1 !== 32'h0) begin errors++; $display("FAIL rst_mid_no_done: %0d bad cycles rd1=%h want 0/0", pulses, read_data1); end
    // last_grant is back to 1, so requester 0 wins a tie.
    req0 = 1'b1; addr0 = 10'h111; req1 = 1'b1; addr1 = 10'h222;
    tick();
    checks++; if (bus.mem_addr !== 10'h111) begin errors++; $display("FAIL rst_first_tie: mem_addr=%h want 111", bus.mem_addr); end
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    r_w_type0 = 1'b0; r_w_type1 = 1'b0;
    addr0 = 10'h000; addr1 = 10'h000;
    write_data0 = 32'h0; write_data1 = 32'h0;
    bus.mem_done = 1'b0;
    bus.mem_read_data = 32'h0;
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_stall();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
